// File: rtl/pcie_tl_cpl_unpacker.sv
// Completion unpacker: pops completion headers and 64-bit payload words from the
// RX completion FIFOs, resolves the tag to its AXI ID and emits AXI4 R beats.
//
// state  | meaning
// IDLE   | waiting for a completion header; pops it and latches its fields
// LOOKUP | tag table answers; latch AXI ID / burst-last and size the completion
// DATA   | forward payload words as OKAY beats straight from the FWFT head
// ERR    | non-SC completion: synthesize zero-data SLVERR beats, no payload pops

package PCIE_PKG;
  typedef struct packed {
    logic [9:0]  tag;
    logic [9:0]  length;
    logic [11:0] byte_count;
    logic [2:0]  cpl_status;
  } tlp_cpl_hdr_t;
endpackage

module pcie_tl_cpl_unpacker
  import PCIE_PKG::*;
#(
  parameter int AXI_ID_WIDTH     = 4,
  parameter int AXI_DATA_WIDTH   = 64,
  parameter int MAX_PAYLOAD_SIZE = 128
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cpl_hdr_empty_i,
  input  tlp_cpl_hdr_t              cpl_hdr_i,
  output logic                      cpl_hdr_rden_o,
  input  logic                      pld_empty_i,
  input  logic [AXI_DATA_WIDTH-1:0] pld_data_i,
  output logic                      pld_rden_o,
  output logic [9:0]                tag_rd_tag_o,
  input  logic [AXI_ID_WIDTH-1:0]   tag_rd_id_i,
  input  logic                      tag_rd_last_i,
  output logic                      tag_release_o,
  output logic                      rvalid_o,
  input  logic                      rready_i,
  output logic [AXI_ID_WIDTH-1:0]   rid_o,
  output logic [AXI_DATA_WIDTH-1:0] rdata_o,
  output logic [1:0]                rresp_o,
  output logic                      rlast_o,
  output logic [15:0]               cpl_err_cnt_o
);

  localparam int MAX_PAYLOAD_DW = MAX_PAYLOAD_SIZE / 4;
  localparam int MAX_BEATS      = MAX_PAYLOAD_DW / 2;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOOKUP = 2'd1,
    S_DATA   = 2'd2,
    S_ERR    = 2'd3
  } state_t;

  state_t                    r_state;
  state_t                    w_next;
  logic [9:0]                r_tag;
  logic [9:0]                r_length;
  logic [11:0]               r_byte_count;
  logic [2:0]                r_status;
  logic [AXI_ID_WIDTH-1:0]   r_id;
  logic                      r_last;
  logic                      r_final;
  logic [5:0]                r_beats;
  logic                      r_tag_release;
  logic [15:0]               r_err_cnt;

  logic [12:0]               w_len13;
  logic [12:0]               w_bc13;
  logic [12:0]               w_data_beats13;
  logic [12:0]               w_err_beats13;
  logic                      w_final;

  // Byte-count math is done 13 bits wide so length<<2 and byte_count+7 never wrap.
  assign w_len13        = {3'b000, r_length};
  assign w_bc13         = {1'b0, r_byte_count};
  assign w_data_beats13 = (w_len13 + 13'd1) >> 1;
  assign w_err_beats13  = (w_bc13 + 13'd7) >> 3;
  assign w_final        = (w_bc13 == (w_len13 << 2));

  // An error completion may report the byte count of the whole remaining request,
  // so the synthesized beat count is clamped to what one MPS completion can carry.
  function automatic logic [5:0] clamp_beats(input logic [12:0] beats);
    if (beats == 13'd0) begin
      return 6'd1;
    end else if (beats > 13'(MAX_BEATS)) begin
      return 6'(MAX_BEATS);
    end else begin
      return beats[5:0];
    end
  endfunction

  assign tag_rd_tag_o  = r_tag;
  assign tag_release_o = r_tag_release;
  assign cpl_err_cnt_o = r_err_cnt;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and R-channel decode; rvalid/rdata pass the FWFT head through in DATA.
  always_comb begin
    w_next         = r_state;
    cpl_hdr_rden_o = 1'b0;
    pld_rden_o     = 1'b0;
    rvalid_o       = 1'b0;
    rid_o          = '0;
    rdata_o        = '0;
    rresp_o        = 2'b00;
    rlast_o        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!cpl_hdr_empty_i) begin
          cpl_hdr_rden_o = 1'b1;
          w_next         = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        w_next = (r_status == 3'b000) ? S_DATA : S_ERR;
      end
      S_DATA: begin
        rvalid_o = !pld_empty_i;
        rdata_o  = pld_data_i;
        rid_o    = r_id;
        rlast_o  = (r_beats == 6'd1) && r_final && r_last;
        if (!pld_empty_i && rready_i) begin
          pld_rden_o = 1'b1;
          if (r_beats == 6'd1) begin
            w_next = S_IDLE;
          end
        end
      end
      S_ERR: begin
        rvalid_o = 1'b1;
        rresp_o  = 2'b10;
        rid_o    = r_id;
        rlast_o  = (r_beats == 6'd1) && r_last;
        if (rready_i && (r_beats == 6'd1)) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Completion context: header fields, lookup result, beat countdown, release and error count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tag         <= '0;
      r_length      <= '0;
      r_byte_count  <= '0;
      r_status      <= '0;
      r_id          <= '0;
      r_last        <= 1'b0;
      r_final       <= 1'b0;
      r_beats       <= '0;
      r_tag_release <= 1'b0;
      r_err_cnt     <= '0;
    end else begin
      r_tag_release <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cpl_hdr_rden_o) begin
            r_tag        <= cpl_hdr_i.tag;
            r_length     <= cpl_hdr_i.length;
            r_byte_count <= cpl_hdr_i.byte_count;
            r_status     <= cpl_hdr_i.cpl_status;
          end
        end
        S_LOOKUP: begin
          r_id    <= tag_rd_id_i;
          r_last  <= tag_rd_last_i;
          r_final <= w_final;
          r_beats <= (r_status == 3'b000) ? clamp_beats(w_data_beats13)
                                          : clamp_beats(w_err_beats13);
        end
        S_DATA: begin
          if (pld_rden_o) begin
            r_beats <= r_beats - 6'd1;
            if ((r_beats == 6'd1) && r_final) begin
              r_tag_release <= 1'b1;
            end
          end
        end
        S_ERR: begin
          if (rready_i) begin
            r_beats <= r_beats - 6'd1;
            if (r_beats == 6'd1) begin
              r_tag_release <= 1'b1;
              if (r_err_cnt != 16'hFFFF) begin
                r_err_cnt <= r_err_cnt + 16'd1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
